// File: rtl/tick_gen_if.sv
// ============================================================================
//  Module      : tick_gen_if
//  Description : Control/status bundle between a controller and tick_gen.
//                The master side drives run control and the period/burst
//                settings; the slave side (tick_gen) returns the enable
//                pulse and run status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tick_gen_if #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] burst_len;
    logic               en;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] pulse_cnt;

    modport master (
        output start, stop, mode, div, burst_len,
        input  en, busy, done, pulse_cnt
    );

    modport slave (
        input  start, stop, mode, div, burst_len,
        output en, busy, done, pulse_cnt
    );
endinterface

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
//  Module      : tick_gen
//  Description : Programmable enable-pulse generator. Emits one-clock en
//                pulses every div+1 clocks, either continuously or as a burst
//                of burst_len pulses. Settings are captured at start so they
//                can be rewritten while a run is in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tick_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div_q;
    logic               r_mode_q;
    logic [BURST_W-1:0] r_burst_len_q;
    logic [DIV_W-1:0]   r_prescale;
    logic               r_en;
    logic               r_busy;
    logic               r_done;
    logic [BURST_W-1:0] r_pulse_cnt;

    // Run control FSM with prescaler, pulse counter and registered outputs.
    // In RUN the priority is: stop, then burst completion, then pulse issue,
    // so a stop on the same edge as a due pulse suppresses that pulse, and a
    // completed burst is detected before the prescaler could fire again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_div_q       <= '0;
            r_mode_q      <= 1'b0;
            r_burst_len_q <= '0;
            r_prescale    <= '0;
            r_en          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pulse_cnt   <= '0;
        end else begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_div_q       <= bus.div;
                        r_mode_q      <= bus.mode;
                        r_burst_len_q <= bus.burst_len;
                        r_prescale    <= '0;
                        r_pulse_cnt   <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_mode_q && (r_pulse_cnt == r_burst_len_q)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (r_prescale == r_div_q) begin
                        r_prescale  <= '0;
                        r_en        <= 1'b1;
                        r_pulse_cnt <= r_pulse_cnt + BURST_W'(1);
                    end else begin
                        r_prescale <= r_prescale + DIV_W'(1);
                    end
                end
                S_FINISH: begin
                    // done is already high for this one cycle; start is not
                    // accepted here, only on the following idle cycle.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en        = r_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pulse_cnt = r_pulse_cnt;

`ifndef SYNTHESIS
    // An enable pulse is only ever issued inside an active run.
    a_en_busy: assert property (@(posedge clk) disable iff (!rst_n) r_en |-> r_busy);
    c_en_busy: cover property (@(posedge clk) disable iff (!rst_n) r_en && r_busy);

    // done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) r_done |=> !r_done);
    c_done_pulse: cover property (@(posedge clk) disable iff (!rst_n) r_done ##1 !r_done);

    // With a period above one clock, pulses are exactly one clock wide.
    a_en_single: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_div_q != '0) && r_en) |=> !r_en);
    c_en_single: cover property (@(posedge clk) disable iff (!rst_n)
        ((r_div_q != '0) && r_en) ##1 !r_en);

    // Outputs are always known.
    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({r_en, r_busy, r_done, r_pulse_cnt}));
    c_no_x: cover property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({r_en, r_busy, r_done, r_pulse_cnt}) && r_busy);
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_gen.sv
// ============================================================================
//  Module      : tb_tick_gen
//  Description : Self-checking bench for tick_gen. Each run is compared cycle
//                by cycle against expected waveforms computed arithmetically
//                from the period, mode, burst length and stop time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_gen;

    localparam int DIV_W   = 16;
    localparam int BURST_W = 8;
    localparam int INF     = 32'h3fff_ffff;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    tick_gen_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

    tick_gen #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // One run: start at edge T0, optional stop sampled at edge T0+s (INF = none).
    // Index k is the edge T0+k; values are checked 1 time unit after it.
    // While the run is active the settings are scrambled and start is
    // re-pulsed at random; none of that may influence the run.
    task automatic run(input int dv, input bit md, input int ln, input int s);
        int p, e, endb, n, kk, expc, pulses, start_lim;
        bit xen;
        p         = dv + 1;
        e         = md ? ln * p + 1 : INF;
        endb      = (e < s) ? e : s;
        start_lim = (e + 1 < s) ? e + 1 : s;
        n         = endb + 3;
        pulses    = 0;
        expc      = 0;
        @(negedge clk);
        bus.div       = DIV_W'(dv);
        bus.mode      = md;
        bus.burst_len = BURST_W'(ln);
        bus.start     = 1'b1;
        bus.stop      = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k <= n; k++) begin
            xen  = (k >= 1) && (k % p == 0) && (k < s) && (!md || (k / p) <= ln);
            kk   = (k < s) ? k : s - 1;
            expc = kk / p;
            if (md && expc > ln) expc = ln;
            chk("en",        k, 32'(bus.en),        32'(xen));
            chk("busy",      k, 32'(bus.busy),      32'(k < endb));
            chk("done",      k, 32'(bus.done),      32'(md && (k == e) && (e < s)));
            chk("pulse_cnt", k, 32'(bus.pulse_cnt), 32'(expc % 256));
            if (bus.en) pulses++;
            bus.start     = (k + 1 <= start_lim) ? ($urandom_range(3) == 0) : 1'b0;
            bus.stop      = (k + 1 == s);
            bus.div       = DIV_W'($urandom);
            bus.mode      = 1'($urandom);
            bus.burst_len = BURST_W'($urandom);
            @(posedge clk); #1;
        end
        chk("downstream_count", n, 32'(pulses), 32'(expc));
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        int dv, ln, e, s;
        bit md;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.mode      = 1'b0;
        bus.div       = '0;
        bus.burst_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en",   0, 32'(bus.en),        32'd0);
        chk("rst_busy", 0, 32'(bus.busy),      32'd0);
        chk("rst_done", 0, 32'(bus.done),      32'd0);
        chk("rst_cnt",  0, 32'(bus.pulse_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed runs from the plan
        run(3, 1'b1, 4, INF);
        run(0, 1'b1, 5, INF);
        run(1, 1'b0, 0, 9);
        run(4, 1'b1, 0, INF);

        // Simultaneous start and stop while idle: stays idle
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1;
        bus.div = 16'd2; bus.mode = 1'b1; bus.burst_len = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("ss_busy", 0, 32'(bus.busy), 32'd0);
        chk("ss_en",   0, 32'(bus.en),   32'd0);
        @(posedge clk); #1;
        chk("ss_busy", 1, 32'(bus.busy), 32'd0);
        chk("ss_done", 1, 32'(bus.done), 32'd0);

        // Burst with settings rewritten and start re-pulsed mid-run
        run(2, 1'b1, 3, INF);

        // Continuous run long enough for pulse_cnt to wrap
        run(0, 1'b0, 0, 300);

        // Randomized runs
        for (int i = 0; i < 20; i++) begin
            dv = int'($urandom_range(4));
            md = 1'($urandom_range(1));
            ln = int'($urandom_range(6));
            if (md) begin
                e = ln * (dv + 1) + 1;
                s = ($urandom_range(1) == 1) ? INF : int'($urandom_range(e + 2, 1));
            end else begin
                s = int'($urandom_range(30, 1));
            end
            run(dv, md, ln, s);
        end

        // Asynchronous reset in the middle of a burst
        @(negedge clk);
        bus.div = 16'd3; bus.mode = 1'b1; bus.burst_len = 8'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_en",   0, 32'(bus.en),        32'd0);
        chk("arst_busy", 0, 32'(bus.busy),      32'd0);
        chk("arst_done", 0, 32'(bus.done),      32'd0);
        chk("arst_cnt",  0, 32'(bus.pulse_cnt), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run(3, 1'b1, 4, INF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
